// File: rtl/KeyDebounce_Pkg.sv
// Shared types and constants for the key debouncer: channel state encoding,
// synchroniser depth and the counter-width helper.
package KeyDebounce_Pkg;

  typedef enum logic [1:0] {
    KD_RELEASED,
    KD_PRESS_WAIT,
    KD_PRESSED,
    KD_RELEASE_WAIT
  } KeyDebState_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Counter only has to reach DEBOUNCE_CYCLES-1, but never narrower than 1 bit.
  function automatic int unsigned kd_cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// Single-key path: 2-flop synchroniser, stability counter and debounce FSM
// with registered level, press/release pulses and busy flag.
module key_debounce_channel
  import KeyDebounce_Pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 300000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyRaw,
  output logic KeyClean,
  output logic PressPulse,
  output logic ReleasePulse,
  output logic Busy
);

  localparam int unsigned       CNT_W    = kd_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_lvl;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  KeyDebState_t           state_q;
  logic                   clean_q;
  logic                   press_q;
  logic                   release_q;
  logic                   busy_q;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], KeyRaw};
  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign cnt_d    = cnt_q + 1'b1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q    <= '1;
      cnt_q     <= '0;
      state_q   <= KD_RELEASED;
      clean_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        KD_RELEASED: begin
          if (!sync_lvl) begin
            state_q <= KD_PRESS_WAIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        KD_PRESS_WAIT: begin
          if (sync_lvl) begin
            // Bounce: fall back to the stable level, nothing accumulates.
            state_q <= KD_RELEASED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= KD_PRESSED;
            clean_q <= 1'b0;
            press_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        KD_PRESSED: begin
          if (sync_lvl) begin
            state_q <= KD_RELEASE_WAIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        KD_RELEASE_WAIT: begin
          if (!sync_lvl) begin
            state_q <= KD_PRESSED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= KD_RELEASED;
            clean_q   <= 1'b1;
            release_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
      endcase
    end
  end

  assign KeyClean     = clean_q;
  assign PressPulse   = press_q;
  assign ReleasePulse = release_q;
  assign Busy         = busy_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces NUM_KEYS active-low push buttons; one fully independent channel
// per key, outputs simply concatenated.
module key_debouncer
  import KeyDebounce_Pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 300000
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] KeysRaw,
  output logic [NUM_KEYS-1:0] KeysClean,
  output logic [NUM_KEYS-1:0] PressPulse,
  output logic [NUM_KEYS-1:0] ReleasePulse,
  output logic [NUM_KEYS-1:0] Busy
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .Clock        (Clock),
      .Reset        (Reset),
      .KeyRaw       (KeysRaw[g]),
      .KeyClean     (KeysClean[g]),
      .PressPulse   (PressPulse[g]),
      .ReleasePulse (ReleasePulse[g]),
      .Busy         (Busy[g])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer: a 4-key DUT with DEBOUNCE_CYCLES = 4 driven
// from a vector table, plus hand sequences for reset-mid-wait and a 1-cycle DUT.
module tb_key_debouncer;

  logic       clk;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] clean, press, rel, busy;
  logic       raw1;
  logic       clean1, press1, rel1, busy1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] busy;
  } vec_t;

  vec_t vecs[$];

  key_debouncer #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4)) dut (
    .Clock        (clk),
    .Reset        (rst),
    .KeysRaw      (raw),
    .KeysClean    (clean),
    .PressPulse   (press),
    .ReleasePulse (rel),
    .Busy         (busy)
  );

  key_debouncer #(.NUM_KEYS(1), .DEBOUNCE_CYCLES(1)) dut1 (
    .Clock        (clk),
    .Reset        (rst),
    .KeysRaw      (raw1),
    .KeysClean    (clean1),
    .PressPulse   (press1),
    .ReleasePulse (rel1),
    .Busy         (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [3:0] rw, input logic [3:0] c,
                              input logic [3:0] p, input logic [3:0] rl, input logic [3:0] b);
    vec_t v;
    v.rst = r; v.raw = rw; v.clean = c; v.press = p; v.rel = rl; v.busy = b;
    vecs.push_back(v);
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 unit after the rising edge.
  task automatic step(input logic r, input logic [3:0] rw, input logic rw1);
    @(negedge clk);
    rst  = r;
    raw  = rw;
    raw1 = rw1;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check(input string name, input logic [3:0] c, input logic [3:0] p,
                       input logic [3:0] rl, input logic [3:0] b);
    cmp({name, ".clean"}, clean, c);
    cmp({name, ".press"}, press, p);
    cmp({name, ".release"}, rel, rl);
    cmp({name, ".busy"}, busy, b);
    cmp({name, ".excl"}, press & rel, 4'h0);
  endtask

  task automatic check1(input string name, input logic c, input logic p,
                        input logic rl, input logic b);
    cmp({name, ".clean1"}, {3'b0, clean1}, {3'b0, c});
    cmp({name, ".press1"}, {3'b0, press1}, {3'b0, p});
    cmp({name, ".release1"}, {3'b0, rel1}, {3'b0, rl});
    cmp({name, ".busy1"}, {3'b0, busy1}, {3'b0, b});
  endtask

  initial begin
    rst  = 1'b1;
    raw  = 4'hF;
    raw1 = 1'b1;

    // Reset then idle
    repeat (3) add(1, 4'hF, 4'hF, 0, 0, 0);
    repeat (2) add(0, 4'hF, 4'hF, 0, 0, 0);
    // Key 0 press held, then released
    repeat (2) add(0, 4'hE, 4'hF, 0, 0, 0);
    repeat (4) add(0, 4'hE, 4'hF, 0, 0, 4'h1);
    add(0, 4'hE, 4'hE, 4'h1, 0, 0);
    add(0, 4'hE, 4'hE, 0, 0, 0);
    repeat (2) add(0, 4'hF, 4'hE, 0, 0, 0);
    repeat (4) add(0, 4'hF, 4'hE, 0, 0, 4'h1);
    add(0, 4'hF, 4'hF, 0, 4'h1, 0);
    add(0, 4'hF, 4'hF, 0, 0, 0);
    // Key 1 short 3-cycle glitch is rejected
    repeat (2) add(0, 4'hD, 4'hF, 0, 0, 0);
    add(0, 4'hD, 4'hF, 0, 0, 4'h2);
    repeat (2) add(0, 4'hF, 4'hF, 0, 0, 4'h2);
    repeat (3) add(0, 4'hF, 4'hF, 0, 0, 0);
    // Key 1 bounces 0,1,0,1 then holds 0
    add(0, 4'hD, 4'hF, 0, 0, 0);
    add(0, 4'hF, 4'hF, 0, 0, 0);
    add(0, 4'hD, 4'hF, 0, 0, 4'h2);
    add(0, 4'hF, 4'hF, 0, 0, 0);
    add(0, 4'hD, 4'hF, 0, 0, 4'h2);
    add(0, 4'hD, 4'hF, 0, 0, 0);
    repeat (4) add(0, 4'hD, 4'hF, 0, 0, 4'h2);
    add(0, 4'hD, 4'hD, 4'h2, 0, 0);
    add(0, 4'hD, 4'hD, 0, 0, 0);
    repeat (2) add(0, 4'hF, 4'hD, 0, 0, 0);
    repeat (4) add(0, 4'hF, 4'hD, 0, 0, 4'h2);
    add(0, 4'hF, 4'hF, 0, 4'h2, 0);
    add(0, 4'hF, 4'hF, 0, 0, 0);
    // All keys pressed together, released straight after acceptance
    repeat (2) add(0, 4'h0, 4'hF, 0, 0, 0);
    repeat (4) add(0, 4'h0, 4'hF, 0, 0, 4'hF);
    add(0, 4'h0, 4'h0, 4'hF, 0, 0);
    repeat (2) add(0, 4'hF, 4'h0, 0, 0, 0);
    repeat (4) add(0, 4'hF, 4'h0, 0, 0, 4'hF);
    add(0, 4'hF, 4'hF, 0, 4'hF, 0);
    add(0, 4'hF, 4'hF, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].raw, 1'b1);
      check($sformatf("vec%0d", i), vecs[i].clean, vecs[i].press, vecs[i].rel, vecs[i].busy);
    end

    // Key 2 reset while in PRESS_WAIT with counter at 2, key held through reset
    for (int k = 1; k <= 5; k++) begin
      step(0, 4'hB, 1'b1);
      check($sformatf("rstwait_e%0d", k), 4'hF, 0, 0, (k >= 3) ? 4'h4 : 4'h0);
    end
    step(1, 4'hB, 1'b1);
    check("rstwait_rst", 4'hF, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 4'hB, 1'b1);
      check($sformatf("rsthold_e%0d", k), (k >= 7) ? 4'hB : 4'hF, (k == 7) ? 4'h4 : 4'h0,
            0, (k >= 3 && k <= 6) ? 4'h4 : 4'h0);
    end
    // Reset while PRESSED: back to released with no release pulse
    step(1, 4'hB, 1'b1);
    check("rstpressed", 4'hF, 0, 0, 0);
    step(0, 4'hF, 1'b1);
    check("rstpressed_after", 4'hF, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 4'hF, 1'b1);
      check($sformatf("rstpressed_idle%0d", k), 4'hF, 0, 0, 0);
    end

    // One-cycle debounce: WAIT lasts a single cycle
    for (int k = 1; k <= 5; k++) begin
      step(0, 4'hF, 1'b0);
      check1($sformatf("d1press_e%0d", k), (k >= 4) ? 1'b0 : 1'b1, k == 4, 1'b0, k == 3);
    end
    step(0, 4'hF, 1'b1);
    check1("d1bounce_e1", 0, 0, 0, 0);
    for (int k = 2; k <= 5; k++) begin
      step(0, 4'hF, 1'b0);
      check1($sformatf("d1bounce_e%0d", k), 1'b0, 1'b0, 1'b0, k == 3);
    end
    for (int k = 1; k <= 5; k++) begin
      step(0, 4'hF, 1'b1);
      check1($sformatf("d1rel_e%0d", k), k >= 4, 1'b0, k == 4, k == 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
